// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues single req/ack reads/writes and stalls the pipeline until done.
// Optional BUSY timeout abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ctrl,
  input  logic [15:0] aluRslt,
  input  logic [15:0] readD2,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        Stall,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;
  logic   access;
  logic   is_wr;
  logic   tmo;
  logic   unused_ctrl;

  assign access      = ctrl[1] | ctrl[2];
  assign is_wr       = ctrl[2];
  assign unused_ctrl = ^{ctrl[15:3], ctrl[0]};

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT must be in 2..255");
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       err_q;

  // Ack in the same cycle as the final count takes priority over the abort.
  assign tmo     = (state == BUSY) && !mem_ack && (tmo_cnt == 8'(TIMEOUT - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != BUSY)
        tmo_cnt <= '0;
      else if (!mem_ack)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          Stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (mem_ack || tmo)
          state_nxt = DONE;
      end
      // ctrl still holds the completed instruction here, so never restart from DONE.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_wr    <= is_wr;
            mem_addr  <= aluRslt;
            mem_wdata <= readD2;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_wr) begin
              rd_data  <= mem_rdata;
              rd_valid <= 1'b1;
            end
          end else if (tmo) begin
            mem_req <= 1'b0;
            if (!mem_wr) begin
              rd_data  <= '1;
              rd_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
